// File: rtl/lkup_mcast_dq.sv
// Multicast dequeue stage: pairs each lookup response with the head packet and replicates it
// to a congestion-pruned subset of egress ports. Statistics counters exist only with LKUP_MCAST_STATS_EN.
module lkup_mcast_dq #(
  parameter int TDATA_WIDTH = 512,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int NUM_EGR     = 4,
  parameter int OCC_WIDTH   = 10,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rsp_fifo_empty,
  output logic                             rsp_fifo_rd,
  input  logic                             rsp_found,
  input  logic                             rsp_drop,
  input  logic [NUM_EGR-1:0]               rsp_dest_mask,
  input  logic                             pkt_fifo_empty,
  output logic                             pkt_fifo_rd,
  input  logic [TDATA_WIDTH-1:0]           pkt_tdata,
  input  logic                             pkt_sop,
  input  logic                             pkt_eop,
  input  logic [$clog2(TKEEP_WIDTH)-1:0]   pkt_bytesvld,
  input  logic [NUM_EGR-1:0]               eg_tready,
  output logic [NUM_EGR-1:0]               eg_tvalid,
  output logic [NUM_EGR*TDATA_WIDTH-1:0]   eg_tdata,
  output logic [NUM_EGR*TKEEP_WIDTH-1:0]   eg_tkeep,
  output logic [NUM_EGR-1:0]               eg_sop,
  output logic [NUM_EGR-1:0]               eg_eop,
  input  logic [NUM_EGR*OCC_WIDTH-1:0]     eg_fifo_occ,
  input  logic [NUM_EGR*OCC_WIDTH-1:0]     cfg_drop_thresh,
  output logic [NUM_EGR*CNT_WIDTH-1:0]     stat_tx_pkt,
  output logic [CNT_WIDTH-1:0]             stat_miss_drop,
  output logic [CNT_WIDTH-1:0]             stat_cong_drop,
  output logic [CNT_WIDTH-1:0]             stat_sop_err
);

  localparam int BV_W = $clog2(TKEEP_WIDTH);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t               state, state_nxt;
  logic [NUM_EGR-1:0]   act_mask, act_mask_nxt;
  logic [NUM_EGR-1:0]   done_mask, done_mask_nxt;
  logic [NUM_EGR-1:0]   cong, act, hs;
  logic                 beat_done;
  logic [BV_W-1:0]      keep_shift;
  logic [TKEEP_WIDTH-1:0] keep;

  always_comb begin
    for (int i = 0; i < NUM_EGR; i++)
      cong[i] = eg_fifo_occ[i*OCC_WIDTH +: OCC_WIDTH] >= cfg_drop_thresh[i*OCC_WIDTH +: OCC_WIDTH];
  end

  assign act = rsp_dest_mask & ~cong;

  // Outstanding ports stay valid until they handshake, since done_mask only grows within a beat.
  assign eg_tvalid = (state == FWD && !pkt_fifo_empty) ? (act_mask & ~done_mask) : '0;
  assign hs        = eg_tvalid & eg_tready;
  assign beat_done = ((done_mask | hs) & act_mask) == act_mask;

  // The subtraction wraps modulo TKEEP_WIDTH, so bytesvld = 0 shifts by 0 and keeps every byte.
  assign keep_shift = BV_W'(TKEEP_WIDTH) - pkt_bytesvld;
  assign keep       = {TKEEP_WIDTH{1'b1}} >> keep_shift;

  assign eg_tdata = {NUM_EGR{pkt_tdata}};
  assign eg_tkeep = {NUM_EGR{keep}};
  assign eg_sop   = {NUM_EGR{pkt_sop}};
  assign eg_eop   = {NUM_EGR{pkt_eop}};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt     = state;
    act_mask_nxt  = act_mask;
    done_mask_nxt = done_mask;
    rsp_fifo_rd   = 1'b0;
    pkt_fifo_rd   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!pkt_fifo_empty) begin
          if (!pkt_sop) begin
            pkt_fifo_rd = 1'b1;
          end else if (!rsp_fifo_empty) begin
            rsp_fifo_rd   = 1'b1;
            act_mask_nxt  = act;
            done_mask_nxt = '0;
            if (!rsp_found || rsp_drop || act == '0) state_nxt = DROP;
            else                                     state_nxt = FWD;
          end
        end
      end
      FWD: begin
        if (!pkt_fifo_empty) begin
          if (beat_done) begin
            pkt_fifo_rd   = 1'b1;
            done_mask_nxt = '0;
            if (pkt_eop) state_nxt = IDLE;
          end else begin
            done_mask_nxt = done_mask | hs;
          end
        end
      end
      DROP: begin
        if (!pkt_fifo_empty) begin
          pkt_fifo_rd = 1'b1;
          if (pkt_eop) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state     <= IDLE;
      act_mask  <= '0;
      done_mask <= '0;
    end else begin
      state     <= state_nxt;
      act_mask  <= act_mask_nxt;
      done_mask <= done_mask_nxt;
    end
  end

`ifdef LKUP_MCAST_STATS_EN
  logic [CNT_WIDTH-1:0] tx_cnt [NUM_EGR];
  logic [CNT_WIDTH-1:0] miss_cnt, cong_cnt, sop_cnt;
  logic                 miss_evt, cong_evt, sop_evt, tx_evt;

  assign miss_evt = rsp_fifo_rd && (!rsp_found || rsp_drop);
  assign cong_evt = rsp_fifo_rd && rsp_found && !rsp_drop && (act == '0);
  assign sop_evt  = (state == IDLE) && pkt_fifo_rd;
  assign tx_evt   = (state == FWD) && pkt_fifo_rd && pkt_eop;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this per-port array is a handful of flops, not a RAM, so resetting it is legal and cheap.
      for (int i = 0; i < NUM_EGR; i++) tx_cnt[i] <= '0;
      miss_cnt <= '0;
      cong_cnt <= '0;
      sop_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_EGR; i++)
        if (tx_evt && act_mask[i]) tx_cnt[i] <= tx_cnt[i] + 1'b1;
      if (miss_evt) miss_cnt <= miss_cnt + 1'b1;
      if (cong_evt) cong_cnt <= cong_cnt + 1'b1;
      if (sop_evt)  sop_cnt  <= sop_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_EGR; g++) begin : g_tx
    assign stat_tx_pkt[g*CNT_WIDTH +: CNT_WIDTH] = tx_cnt[g];
  end
  assign stat_miss_drop = miss_cnt;
  assign stat_cong_drop = cong_cnt;
  assign stat_sop_err   = sop_cnt;
`else
  assign stat_tx_pkt    = '0;
  assign stat_miss_drop = '0;
  assign stat_cong_drop = '0;
  assign stat_sop_err   = '0;
`endif

endmodule

// File: tb/tb_lkup_mcast_dq.sv
// Scoreboard bench for lkup_mcast_dq: models both show-ahead FIFOs, predicts per-port beats
// and counter values, and compares every egress handshake against the expected queue.
module tb_lkup_mcast_dq;
  localparam int TW  = 512;
  localparam int KW  = TW / 8;
  localparam int NE  = 4;
  localparam int OW  = 10;
  localparam int CW  = 32;
  localparam int BVW = $clog2(KW);
`ifdef LKUP_MCAST_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rsp_fifo_empty, rsp_fifo_rd, rsp_found, rsp_drop;
  logic [NE-1:0] rsp_dest_mask;
  logic pkt_fifo_empty, pkt_fifo_rd, pkt_sop, pkt_eop;
  logic [TW-1:0] pkt_tdata;
  logic [BVW-1:0] pkt_bytesvld;
  logic [NE-1:0] eg_tready, eg_tvalid, eg_sop, eg_eop;
  logic [NE*TW-1:0] eg_tdata;
  logic [NE*KW-1:0] eg_tkeep;
  logic [NE*OW-1:0] eg_fifo_occ, cfg_drop_thresh;
  logic [NE*CW-1:0] stat_tx_pkt;
  logic [CW-1:0] stat_miss_drop, stat_cong_drop, stat_sop_err;

  lkup_mcast_dq #(.TDATA_WIDTH(TW), .TKEEP_WIDTH(KW), .NUM_EGR(NE), .OCC_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .rsp_fifo_empty(rsp_fifo_empty), .rsp_fifo_rd(rsp_fifo_rd), .rsp_found(rsp_found),
    .rsp_drop(rsp_drop), .rsp_dest_mask(rsp_dest_mask),
    .pkt_fifo_empty(pkt_fifo_empty), .pkt_fifo_rd(pkt_fifo_rd), .pkt_tdata(pkt_tdata),
    .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_bytesvld(pkt_bytesvld),
    .eg_tready(eg_tready), .eg_tvalid(eg_tvalid), .eg_tdata(eg_tdata), .eg_tkeep(eg_tkeep),
    .eg_sop(eg_sop), .eg_eop(eg_eop), .eg_fifo_occ(eg_fifo_occ), .cfg_drop_thresh(cfg_drop_thresh),
    .stat_tx_pkt(stat_tx_pkt), .stat_miss_drop(stat_miss_drop), .stat_cong_drop(stat_cong_drop),
    .stat_sop_err(stat_sop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic found; logic drop; logic [NE-1:0] mask; } rsp_t;
  typedef struct packed { logic [TW-1:0] data; logic sop; logic eop; logic [BVW-1:0] bv; } beat_t;
  typedef struct { int port; logic [TW-1:0] data; logic sop; logic eop; logic [KW-1:0] keep; } exp_t;

  rsp_t  rsp_q[$];
  beat_t pkt_q[$];
  exp_t  exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int m_tx [NE];
  int m_miss = 0, m_cong = 0, m_sop = 0;

  logic [NE-1:0] s_valid, prev_valid, prev_hs;
  logic          s_pkt_rd, s_rsp_rd, prev_rst;
  logic [CW-1:0] s_miss, s_cong, s_sop;
  logic [NE*CW-1:0] s_tx;

  task automatic check(input string tag, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [KW-1:0] keep_of(input logic [BVW-1:0] bv);
    logic [KW-1:0] k;
    if (bv == 0) k = '1;
    else         k = (KW'(1) << bv) - KW'(1);
    return k;
  endfunction

  task automatic drive_inputs();
    rsp_fifo_empty = (rsp_q.size() == 0);
    pkt_fifo_empty = (pkt_q.size() == 0);
    if (rsp_q.size() != 0) {rsp_found, rsp_drop, rsp_dest_mask} = rsp_q[0];
    else                   {rsp_found, rsp_drop, rsp_dest_mask} = '0;
    if (pkt_q.size() != 0) {pkt_tdata, pkt_sop, pkt_eop, pkt_bytesvld} = pkt_q[0];
    else                   {pkt_tdata, pkt_sop, pkt_eop, pkt_bytesvld} = '0;
  endtask

  // Queue a response plus its beats and predict the outcome from the current occupancy setup.
  task automatic push_pkt(input logic [NE-1:0] mask, input logic found, input logic drop,
                          input int nbeats, input logic [BVW-1:0] last_bv);
    logic [NE-1:0] act;
    beat_t b;
    exp_t  e;
    for (int i = 0; i < NE; i++)
      act[i] = mask[i] && (eg_fifo_occ[i*OW +: OW] < cfg_drop_thresh[i*OW +: OW]);
    rsp_q.push_back('{found: found, drop: drop, mask: mask});
    if (!found || drop) m_miss++;
    else if (act == 0)  m_cong++;
    else for (int i = 0; i < NE; i++) if (act[i]) m_tx[i]++;
    for (int k = 0; k < nbeats; k++) begin
      for (int w = 0; w < TW / 32; w++) b.data[w*32 +: 32] = $urandom;
      b.sop = (k == 0);
      b.eop = (k == nbeats - 1);
      b.bv  = b.eop ? last_bv : '0;
      pkt_q.push_back(b);
      if (found && !drop)
        for (int i = 0; i < NE; i++)
          if (act[i]) begin
            e.port = i; e.data = b.data; e.sop = b.sop; e.eop = b.eop; e.keep = keep_of(b.bv);
            exp_q.push_back(e);
          end
    end
    drive_inputs();
  endtask

  task automatic cycle();
    logic [NE-1:0] cur_hs;
    int idx;
    @(negedge clk);
    s_valid = eg_tvalid; s_pkt_rd = pkt_fifo_rd; s_rsp_rd = rsp_fifo_rd;
    s_miss = stat_miss_drop; s_cong = stat_cong_drop; s_sop = stat_sop_err; s_tx = stat_tx_pkt;
    cur_hs = eg_tvalid & eg_tready;
    if (!prev_rst)
      for (int i = 0; i < NE; i++)
        if (prev_valid[i] && !prev_hs[i]) check($sformatf("tvalid_stable_p%0d", i), eg_tvalid[i], 1'b1);
    for (int i = 0; i < NE; i++) begin
      if (cur_hs[i]) begin
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++) if (idx < 0 && exp_q[j].port == i) idx = j;
        check($sformatf("hs_expected_p%0d", i), idx >= 0, 1'b1);
        if (idx >= 0) begin
          check($sformatf("data_p%0d", i), eg_tdata[i*TW +: TW], exp_q[idx].data);
          check($sformatf("delim_p%0d", i), {eg_sop[i], eg_eop[i]}, {exp_q[idx].sop, exp_q[idx].eop});
          check($sformatf("keep_p%0d", i), eg_tkeep[i*KW +: KW], exp_q[idx].keep);
          exp_q.delete(idx);
        end
      end
    end
    prev_valid = eg_tvalid; prev_hs = cur_hs; prev_rst = rst;
    @(posedge clk);
    #1;
    if (s_pkt_rd && pkt_q.size() != 0) pkt_q.delete(0);
    if (s_rsp_rd && rsp_q.size() != 0) rsp_q.delete(0);
    drive_inputs();
  endtask

  task automatic run_drain(input bit rnd_ready, input int budget, output logic [NE-1:0] any_valid);
    int n = 0;
    any_valid = '0;
    while ((pkt_q.size() != 0 || rsp_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      if (rnd_ready) eg_tready = NE'($urandom);
      cycle();
      any_valid |= s_valid;
      n++;
    end
    eg_tready = '1;
    check("drain_pkt_q", pkt_q.size(), 0);
    check("drain_rsp_q", rsp_q.size(), 0);
    check("drain_exp_q", exp_q.size(), 0);
  endtask

  task automatic check_stats(input string tag);
    cycle();
    cycle();
    check({tag, "_miss"}, s_miss, STATS_EN ? CW'(m_miss) : '0);
    check({tag, "_cong"}, s_cong, STATS_EN ? CW'(m_cong) : '0);
    check({tag, "_sop"},  s_sop,  STATS_EN ? CW'(m_sop)  : '0);
    for (int i = 0; i < NE; i++)
      check($sformatf("%s_tx%0d", tag, i), s_tx[i*CW +: CW], STATS_EN ? CW'(m_tx[i]) : '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, cnt;
    logic [NE-1:0] other, anyv;
    for (int i = 0; i < NE; i++) m_tx[i] = 0;
    rst = 1'b1; eg_tready = '0; eg_fifo_occ = '0;
    prev_valid = '0; prev_hs = '0; prev_rst = 1'b1;
    for (int i = 0; i < NE; i++) cfg_drop_thresh[i*OW +: OW] = OW'(480);
    drive_inputs();
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    check("rst_tvalid", s_valid, '0);
    check("rst_pkt_rd", s_pkt_rd, 1'b0);
    check("rst_rsp_rd", s_rsp_rd, 1'b0);
    check("rst_stat_miss", s_miss, '0);
    check("rst_stat_tx", s_tx, '0);

    // Unicast, 3 beats, all ready.
    eg_tready = '1;
    push_pkt(4'b0001, 1'b1, 1'b0, 3, '0);
    first = -1; last = -1; cnt = 0; other = '0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (s_valid[0]) begin if (first < 0) first = c; last = c; cnt++; end
      other |= s_valid & 4'b1110;
    end
    check("uc_valid_cycles", cnt, 3);
    check("uc_consecutive", last - first + 1, 3);
    check("uc_first_beat_cycle", first, 1);
    check("uc_other_ports", other, '0);
    run_drain(1'b0, 20, anyv);

    // Multicast 0101, port 2 stalls beat 0 for two cycles.
    eg_tready = 4'b1011;
    push_pkt(4'b0101, 1'b1, 1'b0, 2, '0);
    cycle(); check("mc_rsp_pop", s_rsp_rd, 1'b1);
    cycle(); check("mc_b0_valid", s_valid, 4'b0101); check("mc_no_pop1", s_pkt_rd, 1'b0);
    cycle(); check("mc_p0_deassert", s_valid, 4'b0100); check("mc_no_pop2", s_pkt_rd, 1'b0);
    eg_tready = '1;
    cycle(); check("mc_pop_after_p2", s_pkt_rd, 1'b1);
    run_drain(1'b0, 20, anyv);

    // Port 1 congested: partial prune, then full prune.
    eg_fifo_occ[1*OW +: OW] = OW'(500);
    push_pkt(4'b0011, 1'b1, 1'b0, 2, '0);
    run_drain(1'b0, 20, anyv);
    check("cong_p1_silent", anyv[1], 1'b0);
    check("cong_p0_fwd", anyv[0], 1'b1);
    push_pkt(4'b0010, 1'b1, 1'b0, 2, '0);
    run_drain(1'b0, 20, anyv);
    check("cong_drop_no_valid", anyv, '0);
    eg_fifo_occ = '0;

    // Lookup miss, 4 beats, then a normal packet.
    push_pkt(4'b0001, 1'b0, 1'b0, 4, '0);
    cycle(); check("miss_rsp_pop", s_rsp_rd, 1'b1);
    cnt = 0; other = '0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (s_pkt_rd) cnt++;
      other |= s_valid;
    end
    check("miss_pops", cnt, 4);
    check("miss_no_valid", other, '0);
    push_pkt(4'b0001, 1'b1, 1'b0, 2, '0);
    run_drain(1'b0, 20, anyv);

    // Partial-keep on eop: bytesvld 5, then bytesvld 0.
    push_pkt(4'b1000, 1'b1, 1'b0, 2, BVW'(5));
    push_pkt(4'b1000, 1'b1, 1'b0, 1, '0);
    run_drain(1'b0, 20, anyv);

    // Random traffic with random backpressure.
    for (int p = 0; p < 8; p++)
      push_pkt(NE'($urandom_range(1, 15)), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
               $urandom_range(1, 4), BVW'($urandom_range(0, KW - 1)));
    run_drain(1'b1, 400, anyv);
    check_stats("stats");

    // Reset on beat 2 of a 4-beat forward.
    push_pkt(4'b0001, 1'b1, 1'b0, 4, '0);
    cycle(); cycle(); cycle();
    eg_tready = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    eg_tready = '1;
    exp_q.delete();
    for (int i = 0; i < NE; i++) m_tx[i] = 0;
    m_miss = 0; m_cong = 0; m_sop = 2;
    cycle();
    check("rstmid_tvalid", s_valid, '0);
    check("rstmid_rsp_rd", s_rsp_rd, 1'b0);
    check("rstmid_stat_miss", s_miss, '0);
    check("rstmid_stat_cong", s_cong, '0);
    run_drain(1'b0, 20, anyv);
    check("rstmid_no_valid", anyv, '0);
    check_stats("rstmid_stats");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lkup_mcast_dq.md
# lkup_mcast_dq

Multicast-capable dequeue and congestion-management stage for the lookup pipeline. It pairs each lookup response with the head packet in the latency FIFO and replicates that packet to any subset of NUM_EGR egress interfaces. Per-port replication is independently handshaked, and congested ports are pruned at SOP. Packets with a lookup miss, an explicit drop, or a fully pruned destination mask are dropped. The block sits between the TCAM response FIFO / packet latency FIFO and the egress width-adjust stages.

## Interface
Parameters:
- TDATA_WIDTH, 512, packet data width
- TKEEP_WIDTH, TDATA_WIDTH/8, byte enables
- NUM_EGR, 4, egress interfaces (1..16)
- OCC_WIDTH, 10, egress FIFO occupancy width
- CNT_WIDTH, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rsp_fifo_empty  in  1  TCAM response FIFO empty (show-ahead)
- rsp_fifo_rd  out  1  pop response
- rsp_found  in  1  TCAM hit
- rsp_drop  in  1  result drop flag
- rsp_dest_mask  in  NUM_EGR  destination port mask
- pkt_fifo_empty  in  1  latency FIFO empty (show-ahead)
- pkt_fifo_rd  out  1  pop packet beat
- pkt_tdata  in  TDATA_WIDTH  head beat data
- pkt_sop, pkt_eop  in  1 each  head beat delimiters
- pkt_bytesvld  in  $clog2(TKEEP_WIDTH)  valid bytes (0 = all bytes valid)
- eg_tready  in  NUM_EGR  per-port ready
- eg_tvalid  out  NUM_EGR  per-port valid
- eg_tdata  out  NUM_EGR×TDATA_WIDTH  replicated data
- eg_tkeep  out  NUM_EGR×TKEEP_WIDTH  replicated keep, LSB-aligned
- eg_sop, eg_eop  out  NUM_EGR each  replicated delimiters
- eg_fifo_occ  in  NUM_EGR×OCC_WIDTH  downstream FIFO occupancy
- cfg_drop_thresh  in  NUM_EGR×OCC_WIDTH  per-port congestion threshold
- stat_tx_pkt  out  NUM_EGR×CNT_WIDTH  per-port packets forwarded
- stat_miss_drop, stat_cong_drop, stat_sop_err  out  CNT_WIDTH each

## Operation
- The FSM has three states: IDLE, FWD and DROP.
- **IDLE**, when `!rsp_fifo_empty & !pkt_fifo_empty & pkt_sop`:
  - Pulse rsp_fifo_rd.
  - Compute `act = rsp_dest_mask & ~cong`, where `cong[i] = eg_fifo_occ[i] >= cfg_drop_thresh[i]`.
  - Latch act into act_mask and clear done_mask.
  - If `!rsp_found | rsp_drop`: go to DROP, stat_miss_drop++.
  - Else if `act == 0`: go to DROP, stat_cong_drop++.
  - Else go to FWD.
- **IDLE** with the head beat not SOP (and pkt FIFO non-empty): pop and discard the beat, stat_sop_err++. No response is consumed.
- **FWD**:
  - `eg_tvalid[i] = act_mask[i] & ~done_mask[i] & ~pkt_fifo_empty`.
  - A handshake on port i sets done_mask[i].
  - Beat complete = every act_mask bit is set in (done_mask | handshakes this cycle). On beat complete: pkt_fifo_rd = 1 and done_mask clears.
  - If the completed beat is pkt_eop: stat_tx_pkt[i]++ for each act_mask bit, then go to IDLE.
- **DROP**: pop one beat per cycle while non-empty, eg_tvalid = 0. Go to IDLE after popping the eop beat. A single-beat packet takes one cycle in DROP.
- Data, keep and delimiters are driven identically on all ports from the FIFO head.
- `eg_tkeep = {TKEEP_WIDTH{1}} >> (TKEEP_WIDTH − bytesvld)` modulo TKEEP_WIDTH, so bytesvld = 0 yields all ones.
- Congestion is sampled only at SOP; the mask is held for the whole packet.
- A port's tvalid, once asserted, is not dropped until that port handshakes (AXI-S stable).
- Counters wrap on overflow.

## Timing
- Reset values: state IDLE, act_mask/done_mask 0, all eg_tvalid 0, rsp_fifo_rd 0, pkt_fifo_rd 0, all counters 0.
- Decision latency: 1 cycle. The IDLE cycle pops the response; the first beat is presented in the following FWD cycle.
- Throughput: 1 beat/cycle when all active ports are ready. There is one IDLE bubble per packet.
- All outputs except counters are combinational from state, FIFO head and eg_tready. Counters are registered and update the cycle after the triggering event.
- Reset mid-packet returns to IDLE. Leftover non-SOP beats are later discarded and counted in stat_sop_err.
- Simultaneous handshakes on all ports complete the beat in that same cycle.
- An empty FIFO in FWD/DROP stalls: no valid, no pop, no state change.

## Configuration
- With `LKUP_MCAST_STATS_EN` defined: all stat_* counters are implemented as specified.
- Without it: stat_* outputs are tied to 0 and no counter flops are synthesised. Datapath behaviour is identical.

## Test plan
- Unicast hit, mask 0001, 3-beat packet, all ready:
  - eg_tvalid[0] for 3 consecutive cycles, other ports silent.
  - stat_tx_pkt[0] = 1.
- Multicast mask 0101, eg_tready[2] low for 2 cycles on beat 0:
  - Port 0 handshakes once and its tvalid deasserts.
  - pkt_fifo_rd only after port 2 accepts.
  - Both ports receive identical 2-beat packets.
- Mask 0011, eg_fifo_occ[1] = 500 with thresh = 480:
  - Only port 0 forwards.
  - Mask 0010 under the same condition drops the packet, stat_cong_drop = 1, no eg_tvalid.
- Miss (rsp_found = 0), 4-beat packet:
  - 4 pops over 4 cycles, eg_tvalid = 0 throughout, stat_miss_drop = 1, then the next packet forwards normally.
- Reset asserted on beat 2 of a 4-beat forward:
  - All outputs return to 0.
  - The remaining 2 non-SOP beats are discarded, stat_sop_err = 2.
- bytesvld = 5 on the eop beat with TKEEP_WIDTH = 64: eg_tkeep = 0x1F. bytesvld = 0 gives all ones.
